// File: rtl/memory_h_seq_if.sv
// Bundle of the sequencer's command, data and memory-address signals.
// Parameters: WIDTH (h value width), ADDR_W (h memory address width).
// Signals:
//   start, rev_start  forward / backward sequence requests
//   h_valid, h_i      per-cell h value from the LSTM cells
//   rd_next           BPTT consumer advance request
//   wr, wr_addr, h_o  write port toward the h memory
//   rd_addr, t_o      read base address and current timestep
//   step_go, busy, done, rev_done  status / pulses
// Modports: master drives the requests and h data; slave is the sequencer.
interface memory_h_seq_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 9
);
  logic                     start;
  logic                     h_valid;
  logic signed [WIDTH-1:0]  h_i;
  logic                     rev_start;
  logic                     rd_next;
  logic                     wr;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [WIDTH-1:0]  h_o;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        t_o;
  logic                     step_go;
  logic                     busy;
  logic                     done;
  logic                     rev_done;

  modport master (
    output start, h_valid, h_i, rev_start, rd_next,
    input  wr, wr_addr, h_o, rd_addr, t_o, step_go, busy, done, rev_done
  );

  modport slave (
    input  start, h_valid, h_i, rev_start, rd_next,
    output wr, wr_addr, h_o, rd_addr, t_o, step_go, busy, done, rev_done
  );
endinterface

// File: rtl/memory_h_seq.sv
// Write/read address sequencer in front of the hidden-state (h) memory.
// Forward pass: writes each cell's h to slot t*NUM_LSTM+cell and presents the
// read base of the previous timestep's h vector. BPTT pass: walks the read base
// back from the last timestep down to timestep 0. Slot group t=0 holds the
// initial h loaded by the memory itself.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  memory_h_seq_if.slave: start, h_valid, h_i, rev_start, rd_next in;
//        wr, wr_addr, h_o, rd_addr, t_o, step_go, busy, done, rev_done out
//        (all outputs registered)
module memory_h_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_LSTM = 2,
  parameter int unsigned TIMESTEP = 7,
  parameter int unsigned ADDR_W   = 9
) (
  input  logic           clk,
  input  logic           rst,
  memory_h_seq_if.slave  bus
);

  localparam int unsigned CELL_W = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_REV   = 2'd3;

  localparam logic [ADDR_W-1:0] NL_A      = ADDR_W'(NUM_LSTM);
  localparam logic [ADDR_W-1:0] TS_A      = ADDR_W'(TIMESTEP);
  localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NUM_LSTM - 1);

  logic [1:0]               state_q,    state_d;
  logic [CELL_W-1:0]        cell_q,     cell_d;
  logic [ADDR_W-1:0]        t_q,        t_d;
  logic [ADDR_W-1:0]        rd_addr_q,  rd_addr_d;
  logic [ADDR_W-1:0]        wr_addr_q,  wr_addr_d;
  logic signed [WIDTH-1:0]  h_q,        h_d;
  logic                     wr_q,       wr_d;
  logic                     step_go_q,  step_go_d;
  logic                     busy_q,     busy_d;
  logic                     done_q,     done_d;
  logic                     rev_done_q, rev_done_d;

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cell_q     <= '0;
      t_q        <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      h_q        <= '0;
      wr_q       <= 1'b0;
      step_go_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rev_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      t_q        <= t_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      h_q        <= h_d;
      wr_q       <= wr_d;
      step_go_q  <= step_go_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rev_done_q <= rev_done_d;
    end
  end

  // Next-state and next-output logic; pulses default low, counters hold.
  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    t_d        = t_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    h_d        = h_q;
    wr_d       = 1'b0;
    step_go_d  = 1'b0;
    done_d     = 1'b0;
    rev_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start has priority over rev_start
        if (bus.start) begin
          state_d   = ST_RUN;
          t_d       = ADDR_W'(1);
          cell_d    = '0;
          rd_addr_d = '0;
          step_go_d = 1'b1;
        end else if (bus.rev_start) begin
          state_d   = ST_REV;
          rd_addr_d = TS_A * NL_A;
          t_d       = TS_A;
        end
      end

      ST_RUN: begin
        if (bus.h_valid) begin
          wr_d      = 1'b1;
          wr_addr_d = t_q * NL_A + ADDR_W'(cell_q);
          h_d       = bus.h_i;
          if (cell_q == LAST_CELL) begin
            cell_d  = '0;
            state_d = ST_FLUSH;
          end else begin
            cell_d  = cell_q + CELL_W'(1);
          end
        end
      end

      // One idle cycle so the last write of the timestep lands before
      // step_go tells the cells that the next read base is valid.
      ST_FLUSH: begin
        if (t_q < TS_A) begin
          rd_addr_d = t_q * NL_A;
          t_d       = t_q + ADDR_W'(1);
          step_go_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_REV: begin
        if (bus.rd_next) begin
          if (t_q != '0) begin
            rd_addr_d = rd_addr_q - NL_A;
            t_d       = t_q - ADDR_W'(1);
          end else begin
            rev_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.wr       = wr_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.h_o      = h_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.t_o      = t_q;
  assign bus.step_go  = step_go_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rev_done = rev_done_q;

endmodule

// File: tb/tb_memory_h_seq.sv
// Directed bench for memory_h_seq with NUM_LSTM=2, TIMESTEP=7, plus a simple
// h memory model fed by the write port.
module tb_memory_h_seq;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned NUM_LSTM = 2;
  localparam int unsigned TIMESTEP = 7;
  localparam int unsigned ADDR_W   = 9;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [WIDTH-1:0] mem [0:511];

  memory_h_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  memory_h_seq #(
    .WIDTH(WIDTH), .NUM_LSTM(NUM_LSTM), .TIMESTEP(TIMESTEP), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // h memory model: captures the registered write strobe
  always @(posedge clk) begin
    if (bus.wr) mem[bus.wr_addr] <= bus.h_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"},       32'(bus.wr),       32'h0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'h0);
    chk({tag, "_h_o"},      32'(bus.h_o),      32'h0);
    chk({tag, "_rd_addr"},  32'(bus.rd_addr),  32'h0);
    chk({tag, "_t_o"},      32'(bus.t_o),      32'h0);
    chk({tag, "_step_go"},  32'(bus.step_go),  32'h0);
    chk({tag, "_busy"},     32'(bus.busy),     32'h0);
    chk({tag, "_done"},     32'(bus.done),     32'h0);
    chk({tag, "_rev_done"}, 32'(bus.rev_done), 32'h0);
  endtask

  // Full forward sequence; gap idle cycles precede every h_valid.
  // inject drives start during gaps and h_valid during FLUSH (both ignored).
  task automatic do_forward(input int gap, input bit inject, input bit both_start);
    bus.start     = 1'b1;
    bus.rev_start = both_start;
    tick;
    bus.start     = 1'b0;
    bus.rev_start = 1'b0;
    chk("start_step_go", 32'(bus.step_go), 32'h1);
    chk("start_t_o",     32'(bus.t_o),     32'h1);
    chk("start_rd_addr", 32'(bus.rd_addr), 32'h0);
    chk("start_busy",    32'(bus.busy),    32'h1);
    chk("start_wr",      32'(bus.wr),      32'h0);
    for (int t = 1; t <= 7; t++) begin
      for (int c = 0; c < 2; c++) begin
        for (int g = 0; g < gap; g++) begin
          bus.h_valid = 1'b0;
          bus.start   = inject;
          tick;
          bus.start   = 1'b0;
          chk("gap_wr",      32'(bus.wr),      32'h0);
          chk("gap_t_o",     32'(bus.t_o),     32'(t));
          chk("gap_step_go", 32'(bus.step_go), 32'h0);
        end
        bus.h_valid = 1'b1;
        bus.h_i     = 32'(16 * t + c);
        tick;
        bus.h_valid = 1'b0;
        chk("wr",      32'(bus.wr),      32'h1);
        chk("wr_addr", 32'(bus.wr_addr), 32'(2 * t + c));
        chk("h_o",     32'(bus.h_o),     32'(16 * t + c));
        chk("wr_step_go", 32'(bus.step_go), 32'h0);
      end
      // FLUSH cycle
      bus.h_valid = inject;
      bus.h_i     = 32'hDEAD_BEEF;
      tick;
      bus.h_valid = 1'b0;
      chk("flush_wr", 32'(bus.wr), 32'h0);
      if (t < 7) begin
        chk("flush_step_go", 32'(bus.step_go), 32'h1);
        chk("flush_rd_addr", 32'(bus.rd_addr), 32'(2 * t));
        chk("flush_t_o",     32'(bus.t_o),     32'(t + 1));
        chk("flush_done",    32'(bus.done),    32'h0);
      end else begin
        chk("done",         32'(bus.done),    32'h1);
        chk("done_busy",    32'(bus.busy),    32'h0);
        chk("done_t_o",     32'(bus.t_o),     32'd7);
        chk("done_rd_addr", 32'(bus.rd_addr), 32'd12);
        chk("done_step_go", 32'(bus.step_go), 32'h0);
      end
    end
    tick;
    chk("done_pulse", 32'(bus.done), 32'h0);
  endtask

  task automatic chk_mem;
    for (int t = 1; t <= 7; t++) begin
      for (int c = 0; c < 2; c++) begin
        chk("mem", mem[2 * t + c], 32'(16 * t + c));
      end
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.h_valid   = 1'b0;
    bus.h_i       = '0;
    bus.rev_start = 1'b0;
    bus.rd_next   = 1'b0;

    // reset values
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b0;
    tick;

    // reset mid-RUN aborts asynchronously
    bus.start = 1'b1;
    tick;
    bus.start   = 1'b0;
    bus.h_valid = 1'b1;
    bus.h_i     = 32'h10;
    tick;
    bus.h_i     = 32'h11;
    tick;
    bus.h_valid = 1'b0;
    chk("pre_rst_wr",      32'(bus.wr),      32'h1);
    chk("pre_rst_wr_addr", 32'(bus.wr_addr), 32'h3);
    chk("pre_rst_busy",    32'(bus.busy),    32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick;
    rst = 1'b0;
    tick;
    chk_zero("post_rst");

    // h_valid in IDLE is ignored
    bus.h_valid = 1'b1;
    bus.h_i     = 32'h55;
    tick;
    bus.h_valid = 1'b0;
    chk("idle_hv_wr",   32'(bus.wr),   32'h0);
    chk("idle_hv_busy", 32'(bus.busy), 32'h0);
    chk("idle_hv_h_o",  32'(bus.h_o),  32'h0);

    // back-to-back forward run
    do_forward(0, 1'b0, 1'b0);
    chk_mem();

    // backward walk; start/h_valid during REV ignored
    bus.rev_start = 1'b1;
    tick;
    bus.rev_start = 1'b0;
    chk("rev_rd_addr", 32'(bus.rd_addr), 32'd14);
    chk("rev_t_o",     32'(bus.t_o),     32'd7);
    chk("rev_busy",    32'(bus.busy),    32'h1);
    for (int k = 1; k <= 8; k++) begin
      bus.rd_next = 1'b1;
      bus.start   = (k == 1);
      bus.h_valid = (k == 1);
      tick;
      bus.start   = 1'b0;
      bus.h_valid = 1'b0;
      if (k < 8) begin
        chk("rev_step_rd_addr", 32'(bus.rd_addr),  32'(14 - 2 * k));
        chk("rev_step_t_o",     32'(bus.t_o),      32'(7 - k));
        chk("rev_step_done",    32'(bus.rev_done), 32'h0);
        chk("rev_step_wr",      32'(bus.wr),       32'h0);
      end else begin
        chk("rev_done",         32'(bus.rev_done), 32'h1);
        chk("rev_done_busy",    32'(bus.busy),     32'h0);
        chk("rev_done_rd_addr", 32'(bus.rd_addr),  32'h0);
        chk("rev_done_t_o",     32'(bus.t_o),      32'h0);
      end
    end
    bus.rd_next = 1'b0;
    tick;
    chk("rev_done_pulse", 32'(bus.rev_done), 32'h0);
    chk("rev_idle_busy",  32'(bus.busy),     32'h0);

    // gapped run, start+rev_start together, protocol noise injected
    do_forward(2, 1'b1, 1'b1);
    chk_mem();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
